// File: rtl/sha1_multiround_if.sv
// Register-bus bundle for sha1_multiround: chip select, write strobe, word
// address, write data and combinational read data.
interface sha1_multiround_if;
   logic        cs;
   logic        we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (output cs, output we, output address, output write_data, input read_data);
   modport slave  (input cs, input we, input address, input write_data, output read_data);
endinterface

// File: rtl/sha1_multiround.sv
// SHA-1 / SHA-0 compression core with a register bus, performing
// ROUNDS_PER_CYCLE chained rounds per clock over a sliding 16-word schedule.
module sha1_multiround #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic clk,
   input  logic reset,
   sha1_multiround_if.slave bus
);
   localparam int R = ROUNDS_PER_CYCLE;

   if (!(R == 1 || R == 2 || R == 4 || R == 5)) begin : g_bad_rounds
      $error("sha1_multiround: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, ROUNDS = 2'd1, DONE = 2'd2} state_t;

   function automatic logic [31:0] f_sched(input logic sha0, input logic [31:0] x);
      return sha0 ? x : {x[30:0], x[31]};
   endfunction

   function automatic logic [31:0] f_func(input logic [1:0] sel, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
      case (sel)
         2'd0:    return (b & c) | (~b & d);
         2'd2:    return (b & c) | (b & d) | (c & d);
         default: return b ^ c ^ d;
      endcase
   endfunction

   function automatic logic [31:0] f_k(input logic [1:0] sel);
      case (sel)
         2'd0:    return 32'h5a827999;
         2'd1:    return 32'h6ed9eba1;
         2'd2:    return 32'h8f1bbcdc;
         default: return 32'hca62c1d6;
      endcase
   endfunction

   state_t      r_state, w_next_state;
   logic [31:0] r_h [5];
   logic [31:0] r_v [5];
   logic [31:0] r_w [16];
   logic [6:0]  r_t;
   logic        r_mode, r_valid, r_wr_err;

   logic        w_wr, w_ctrl_wr, w_blk_wr, w_accept, w_last, w_err_set, w_err_clr;
   logic [1:0]  w_sel;
   logic [31:0] w_tmp;
   logic [31:0] w_ext [16+R];
   logic [31:0] w_v [R+1][5];
   logic [31:0] w_rdata;

   assign w_wr      = bus.cs && bus.we;
   assign w_ctrl_wr = w_wr && (bus.address == 8'h08);
   assign w_blk_wr  = w_wr && (bus.address[7:4] == 4'h1);
   assign w_accept  = w_ctrl_wr && (r_state == IDLE) && (bus.write_data[0] || bus.write_data[1]);
   assign w_err_set = (w_ctrl_wr || w_blk_wr) && (r_state != IDLE);
   assign w_err_clr = w_wr && (bus.address == 8'h09) && bus.write_data[2];
   assign w_last    = (r_t == 7'(80 - R));

   // Extend the schedule window by R words and chain R rounds off it
   always_comb begin
      w_tmp = 32'd0;
      if (r_t < 7'd20) begin
         w_sel = 2'd0;
      end else if (r_t < 7'd40) begin
         w_sel = 2'd1;
      end else if (r_t < 7'd60) begin
         w_sel = 2'd2;
      end else begin
         w_sel = 2'd3;
      end
      for (int j = 0; j < 16; j++) w_ext[j] = r_w[j];
      for (int i = 0; i < R; i++)
         w_ext[16+i] = f_sched(r_mode, w_ext[13+i] ^ w_ext[8+i] ^ w_ext[2+i] ^ w_ext[i]);
      for (int k = 0; k < 5; k++) w_v[0][k] = r_v[k];
      for (int i = 0; i < R; i++) begin
         w_tmp = {w_v[i][0][26:0], w_v[i][0][31:27]} + f_func(w_sel, w_v[i][1], w_v[i][2], w_v[i][3])
               + w_v[i][4] + f_k(w_sel) + w_ext[i];
         w_v[i+1][4] = w_v[i][3];
         w_v[i+1][3] = w_v[i][2];
         w_v[i+1][2] = {w_v[i][1][1:0], w_v[i][1][31:2]};
         w_v[i+1][1] = w_v[i][0];
         w_v[i+1][0] = w_tmp;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    w_next_state = w_accept ? ROUNDS : IDLE;
         ROUNDS:  w_next_state = w_last ? DONE : ROUNDS;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Hash state, schedule window, round counter and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 5; k++) begin
            r_h[k] <= 32'd0;
            r_v[k] <= 32'd0;
         end
         r_t      <= 7'd0;
         r_mode   <= 1'b0;
         r_valid  <= 1'b0;
         r_wr_err <= 1'b0;
      end else begin
         if (w_err_set)      r_wr_err <= 1'b1;
         else if (w_err_clr) r_wr_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_blk_wr) r_w[bus.address[3:0]] <= bus.write_data;
               if (w_accept) begin
                  r_mode  <= bus.write_data[2];
                  r_valid <= 1'b0;
                  r_t     <= 7'd0;
                  if (bus.write_data[0]) begin
                     r_h[0] <= 32'h67452301; r_v[0] <= 32'h67452301;
                     r_h[1] <= 32'hefcdab89; r_v[1] <= 32'hefcdab89;
                     r_h[2] <= 32'h98badcfe; r_v[2] <= 32'h98badcfe;
                     r_h[3] <= 32'h10325476; r_v[3] <= 32'h10325476;
                     r_h[4] <= 32'hc3d2e1f0; r_v[4] <= 32'hc3d2e1f0;
                  end else begin
                     for (int k = 0; k < 5; k++) r_v[k] <= r_h[k];
                  end
               end
            end
            ROUNDS: begin
               for (int k = 0; k < 5; k++)  r_v[k] <= w_v[R][k];
               for (int j = 0; j < 16; j++) r_w[j] <= w_ext[j+R];
               r_t <= r_t + 7'(R);
            end
            DONE: begin
               for (int k = 0; k < 5; k++) r_h[k] <= r_h[k] + r_v[k];
               r_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Read mux; the digest stays hidden until it is valid
   always_comb begin
      w_rdata = 32'd0;
      case (bus.address)
         8'h09:   w_rdata = {29'd0, r_wr_err, r_valid, (r_state == IDLE)};
         8'h0A:   w_rdata = {24'd0, 8'(R)};
         8'h20:   w_rdata = r_valid ? r_h[0] : 32'd0;
         8'h21:   w_rdata = r_valid ? r_h[1] : 32'd0;
         8'h22:   w_rdata = r_valid ? r_h[2] : 32'd0;
         8'h23:   w_rdata = r_valid ? r_h[3] : 32'd0;
         8'h24:   w_rdata = r_valid ? r_h[4] : 32'd0;
         default: w_rdata = 32'd0;
      endcase
   end

   assign bus.read_data = w_rdata;
endmodule

// File: tb/tb_sha1_multiround.sv
// Drives four sha1_multiround instances (R = 1, 2, 4, 5) with one shared bus
// stream and checks every instance against a straightforward SHA-1/SHA-0 model.
module tb_sha1_multiround;
   logic        clk = 1'b0;
   logic        reset, cs, we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] rd [4];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_blk [16];
   logic [31:0] m_h [5];
   logic [31:0] kat [5];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int RP = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 5;
      sha1_multiround_if bus_if ();
      assign bus_if.cs         = cs;
      assign bus_if.we         = we;
      assign bus_if.address    = address;
      assign bus_if.write_data = write_data;
      assign rd[g]             = bus_if.read_data;
      sha1_multiround #(.ROUNDS_PER_CYCLE(RP)) u_dut (.clk(clk), .reset(reset), .bus(bus_if));
   end

   function automatic int r_of(input int g);
      case (g)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         default: return 5;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; address = a; write_data = d;
      @(posedge clk);
      #1;
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a);
      @(negedge clk);
      address = a;
      #1;
   endtask

   task automatic set_iv();
      m_h[0] = 32'h67452301; m_h[1] = 32'hefcdab89; m_h[2] = 32'h98badcfe;
      m_h[3] = 32'h10325476; m_h[4] = 32'hc3d2e1f0;
   endtask

   // Textbook compression: full 80-word expansion, then 80 sequential rounds
   task automatic ref_compress(input bit sha0);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, x, tmp;
      for (int t = 0; t < 16; t++) w[t] = m_blk[t];
      for (int t = 16; t < 80; t++) begin
         x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
         w[t] = sha0 ? x : {x[30:0], x[31]};
      end
      a = m_h[0]; b = m_h[1]; c = m_h[2]; d = m_h[3]; e = m_h[4];
      for (int t = 0; t < 80; t++) begin
         if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
         else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
         else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
         else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
         tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
      end
      m_h[0] += a; m_h[1] += b; m_h[2] += c; m_h[3] += d; m_h[4] += e;
   endtask

   task automatic check_all(input string tag, input logic [7:0] a, input logic [31:0] exp);
      bus_read(a);
      for (int g = 0; g < 4; g++) check($sformatf("%s_r%0d", tag, r_of(g)), rd[g], exp);
   endtask

   task automatic check_digest(input string tag);
      for (int k = 0; k < 5; k++) check_all($sformatf("%s_h%0d", tag, k), 8'h20 + 8'(k), m_h[k]);
   endtask

   task automatic check_kat(input string tag);
      for (int k = 0; k < 5; k++) check_all($sformatf("%s_kat%0d", tag, k), 8'h20 + 8'(k), kat[k]);
   endtask

   // Count READY=0 cycles per instance and require a zero digest while busy
   task automatic wait_ready(input bit chk_lat, input string tag);
      bit         done [4];
      int         cnt [4];
      logic [3:0] mask;
      for (int g = 0; g < 4; g++) begin done[g] = 1'b0; cnt[g] = 0; end
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         address = 8'h09;
         #1;
         for (int g = 0; g < 4; g++)
            if (!done[g]) begin
               if (rd[g][0] === 1'b1) done[g] = 1'b1;
               else cnt[g]++;
            end
         address = 8'h20 + 8'(cyc % 5);
         #1;
         for (int g = 0; g < 4; g++)
            if (!done[g]) check($sformatf("%s_busy_dig_r%0d", tag, r_of(g)), rd[g], 32'd0);
         if (done[0] && done[1] && done[2] && done[3]) break;
      end
      for (int g = 0; g < 4; g++) mask[g] = done[g];
      check({tag, "_ready_timeout"}, {28'd0, mask}, 32'h0000000f);
      if (chk_lat)
         for (int g = 0; g < 4; g++)
            check($sformatf("%s_latency_r%0d", tag, r_of(g)), 32'(cnt[g]), 32'(80 / r_of(g) + 1));
   endtask

   task automatic load_block();
      for (int i = 0; i < 16; i++) bus_write(8'h10 + 8'(i), m_blk[i]);
   endtask

   task automatic run_hash(input logic [31:0] ctrl, input string tag);
      load_block();
      bus_write(8'h08, ctrl);
      wait_ready(1'b1, tag);
      if (ctrl[0]) set_iv();
      ref_compress(ctrl[2]);
      check_all({tag, "_status"}, 8'h09, 32'h00000003);
      check_digest(tag);
   endtask

   task automatic abc_block();
      for (int i = 0; i < 16; i++) m_blk[i] = 32'd0;
      m_blk[0] = 32'h61626380; m_blk[15] = 32'h00000018;
   endtask

   task automatic abc_kat();
      kat[0] = 32'ha9993e36; kat[1] = 32'h4706816a; kat[2] = 32'hba3e2571;
      kat[3] = 32'h7850c26c; kat[4] = 32'h9cd0d89d;
   endtask

   initial begin
      logic [31:0] ctrl;
      reset = 1'b1; cs = 1'b0; we = 1'b0; address = 8'h00; write_data = 32'd0;
      for (int k = 0; k < 5; k++) m_h[k] = 32'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state and register map
      check_all("rst_status", 8'h09, 32'h00000001);
      check_digest("rst_digest");
      bus_read(8'h0A);
      for (int g = 0; g < 4; g++) check($sformatf("config_r%0d", r_of(g)), rd[g], 32'(r_of(g)));
      check_all("unmapped_00", 8'h00, 32'd0);
      check_all("unmapped_25", 8'h25, 32'd0);
      check_all("ctrl_wo", 8'h08, 32'd0);

      // NEXT straight after reset chains from H = 0
      for (int i = 0; i < 16; i++) m_blk[i] = $urandom;
      run_hash(32'h2, "next_from_zero");

      abc_block(); abc_kat();
      run_hash(32'h1, "abc_sha1");
      check_kat("abc_sha1");

      abc_block();
      run_hash(32'h5, "abc_sha0");
      kat[0] = 32'h0164b8a9; kat[1] = 32'h14cd2a5e; kat[2] = 32'h74c4f7ff;
      kat[3] = 32'h082c4d97; kat[4] = 32'hf1edf880;
      check_kat("abc_sha0");

      // Two-block message chained with NEXT
      m_blk[0]  = 32'h61626364; m_blk[1]  = 32'h62636465; m_blk[2]  = 32'h63646566;
      m_blk[3]  = 32'h64656667; m_blk[4]  = 32'h65666768; m_blk[5]  = 32'h66676869;
      m_blk[6]  = 32'h6768696a; m_blk[7]  = 32'h68696a6b; m_blk[8]  = 32'h696a6b6c;
      m_blk[9]  = 32'h6a6b6c6d; m_blk[10] = 32'h6b6c6d6e; m_blk[11] = 32'h6c6d6e6f;
      m_blk[12] = 32'h6d6e6f70; m_blk[13] = 32'h6e6f7071; m_blk[14] = 32'h80000000;
      m_blk[15] = 32'h00000000;
      run_hash(32'h1, "two_blk1");
      for (int i = 0; i < 16; i++) m_blk[i] = 32'd0;
      m_blk[15] = 32'h000001c0;
      run_hash(32'h2, "two_blk2");
      kat[0] = 32'h84983e44; kat[1] = 32'h1c3bd26e; kat[2] = 32'hbaae4aa1;
      kat[3] = 32'hf95129e5; kat[4] = 32'he54670f1;
      check_kat("two_blk");

      // INIT and NEXT together: INIT wins
      abc_block(); abc_kat();
      run_hash(32'h3, "init_next");
      check_kat("init_next");

      // Neither bit set is a no-op
      bus_write(8'h08, 32'h4);
      check_all("ctrl_noop_status", 8'h09, 32'h00000003);
      check_digest("ctrl_noop");

      // Writes while busy are dropped and flag WR_ERR
      abc_block();
      load_block();
      bus_write(8'h08, 32'h1);
      bus_write(8'h10, 32'hffffffff);
      bus_write(8'h08, 32'h1);
      check_all("busy_status", 8'h09, 32'h00000004);
      wait_ready(1'b0, "busy");
      check_all("busy_done_status", 8'h09, 32'h00000007);
      check_kat("busy");
      bus_write(8'h09, 32'h4);
      check_all("wrerr_clear", 8'h09, 32'h00000003);

      // Reset mid-hash beats a same-cycle CTRL write
      load_block();
      bus_write(8'h08, 32'h1);
      repeat (9) @(negedge clk);
      reset = 1'b1; cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'h1;
      @(posedge clk);
      #1;
      reset = 1'b0; cs = 1'b0; we = 1'b0;
      for (int k = 0; k < 5; k++) m_h[k] = 32'd0;
      check_all("midrst_status", 8'h09, 32'h00000001);
      check_digest("midrst");
      abc_block();
      run_hash(32'h1, "after_rst");
      check_kat("after_rst");

      // Random blocks, modes and INIT/NEXT choices
      for (int it = 0; it < 5; it++) begin
         for (int i = 0; i < 16; i++) m_blk[i] = $urandom;
         ctrl = ($urandom_range(0, 1) != 0) ? 32'h1 : 32'h2;
         if ($urandom_range(0, 1) != 0) ctrl = ctrl | 32'h4;
         run_hash(ctrl, $sformatf("rand%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
